hpi_responder: RTL and testbench
================================

# hpi_responder

Target-side model of the OTG host-port interface (HPI): answers the four-register HPI protocol that the Nios drives through its `otg_hpi_*` PIO exports. It backs the protocol with an internal 16-bit word memory and a bidirectional mailbox. It is instantiated in place of the external USB controller for on-board loopback and bring-up of the HPI driver, and it serves as the responder in HPI driver simulations.

## Interface
- `DEPTH_WORDS`, 1024: internal memory size in 16-bit words. Must be a power of two, ≥ 16.
- `clk`  in  1: system clock. The HPI strobes come from PIOs in the same domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `hpi_addr`  in  2: register select. 0 = DATA, 1 = MAILBOX, 2 = ADDRESS, 3 = STATUS.
- `hpi_cs_n`  in  1: chip select, active low.
- `hpi_r_n`  in  1: read strobe, active low.
- `hpi_w_n`  in  1: write strobe, active low.
- `hpi_data_in`  in  16: data from host.
- `hpi_data_out`  out  16: read data to host.
- `hpi_data_oe`  out  1: high while a legal read is active.
- `hpi_int`  out  1: high while device-to-host mailbox is full.
- `mbx_in_data`  out  16: last host-written mailbox word.
- `mbx_in_valid`  out  1: host-to-device mailbox full.
- `mbx_in_ack`  in  1: local side consumes the mailbox; clears `mbx_in_valid`.
- `mbx_out_data`  in  16: word for host.
- `mbx_out_wr`  in  1: single-cycle load of `mbx_out_data` into device-to-host mailbox.
- `mbx_out_busy`  out  1: equals `hpi_int`.

## Operation
**Access detection**
- `cs_n`, `r_n` and `w_n` are registered each cycle.
- Read access (RD) = `!cs_n & !r_n & w_n`. Write access (WR) = `!cs_n & !w_n & r_n`.
- `cs_n`, `r_n` and `w_n` all low together is illegal: no action, `hpi_data_oe` stays 0.
- Each access acts once, on its asserting edge (the registered previous value was inactive). Holding a strobe never repeats the action.

**Registers**
- ADDRESS: a 16-bit byte address.
  - Memory word index = `addr[log2(DEPTH_WORDS):1]`; upper bits are ignored, so the address wraps modulo the memory size.
  - Bit 0 is stored but ignored.
  - Reads return the stored value.
- DATA write: `mem[index] <= hpi_data_in`.
- DATA read: returns `mem[index]`.
- Auto-increment: see Configuration.
- MAILBOX write: loads `mbx_in_data` and sets `mbx_in_valid`. A write while already full overwrites the data and the flag stays set.
- MAILBOX read: returns the device-to-host word. When the read strobe deasserts, `hpi_int` clears.
- STATUS: read-only; writes are ignored. Bit0 = `mbx_in_valid`, bit1 = `hpi_int`, bits 15:2 = 0.

**Local mailbox side**
- `mbx_out_wr` loads the device-to-host word and sets `hpi_int`. A load while full overwrites the word.
- Same-cycle `mbx_out_wr` and host MAILBOX-read completion: the set wins, so `hpi_int` stays 1 with the new word.
- Same-cycle `mbx_in_ack` and host MAILBOX write: the set wins.

**Read FSM** (states IDLE → FETCH → DRIVE)
- IDLE: on RD edge, latch the register select and issue the synchronous memory read → FETCH.
- FETCH: capture the selected value into the output register → DRIVE.
- DRIVE: `hpi_data_oe` = 1 and `hpi_data_out` is held. When RD deasserts, apply read side effects (DATA increment, mailbox clear) → IDLE.
- If `cs_n` rises at any point, return to IDLE. Side effects apply only if DRIVE was reached.

**Reset**
- All registers clear: ADDRESS = 0, mailbox data = 0, both flags = 0, `hpi_data_out` = 0, `hpi_data_oe` = 0, FSM in IDLE.
- Memory contents are not reset.
- Reset asserted mid-access aborts the access with no side effect.

## Timing
- Edge detect: one cycle after the strobe is sampled low.
- Writes commit on the detect cycle +1, i.e. 2 cycles after the strobe asserts.
- `hpi_data_out` is valid and `hpi_data_oe` = 1 three cycles after the RD strobe asserts. The host must hold a read for ≥ 4 cycles.
- Read side effects occur 2 cycles after RD deasserts.
- Back-to-back accesses need ≥ 1 idle cycle between them.
- `mbx_out_wr` → `hpi_int` high: next cycle.
- `mbx_in_ack` → `mbx_in_valid` low: next cycle.

## Configuration
- `HPI_RESP_AUTOINC_EN` defined: each completed DATA read or write advances ADDRESS by 2 (16-bit add, wraps 0xFFFE → 0x0000). This matches the burst-transfer behaviour of the real device.
- Not defined: ADDRESS changes only through ADDRESS writes, and DATA accesses leave it untouched.

## Test plan
- Burst write with the macro on: write ADDRESS = 0x1000, then DATA 0xAAAA, 0x5555, 0x1234. Required: ADDRESS reads 0x1006; rewrite ADDRESS = 0x1000 and three DATA reads return 0xAAAA, 0x5555, 0x1234.
- Wrap: with `DEPTH_WORDS` = 1024, write ADDRESS = 0x07FE, then DATA 0xBEEF twice. Required: the second write lands at index 0; ADDRESS = 0x0000 reads back 0xBEEF.
- Mailbox round trip: host writes MAILBOX 0x00C3 → `mbx_in_valid` = 1, `mbx_in_data` = 0x00C3, STATUS = 0x0001. Pulse `mbx_in_ack` → STATUS = 0x0000. Then `mbx_out_wr` with 0x0F0F → `hpi_int` = 1; host MAILBOX read returns 0x0F0F and `hpi_int` = 0 two cycles after RD deasserts.
- Collision: `mbx_out_wr` with 0x2222 in the same cycle as a MAILBOX-read completion. Required: `hpi_int` stays 1 and the next MAILBOX read returns 0x2222.
- Illegal and held strobes: `r_n` = `w_n` = `cs_n` = 0 for 10 cycles → no memory change, `hpi_data_oe` = 0. `w_n` held low for 20 cycles on DATA → exactly one write and one increment.
- Reset mid-read: assert `reset_n` low during FETCH → all outputs 0 and ADDRESS = 0 after release; memory contents intact.

Source files
------------

// File: rtl/hpi_responder.sv
// -----------------------------------------------------------------------------
// hpi_responder
//
// Target-side model of the OTG host-port interface (HPI). It answers the
// four-register HPI protocol (DATA, MAILBOX, ADDRESS, STATUS) that the Nios
// drives through its otg_hpi_* PIO exports. It backs the protocol with an
// internal 16-bit word memory and a bidirectional mailbox. It stands in for
// the external USB controller during on-board loopback and in HPI driver
// simulations.
//
// Optional feature macro: HPI_RESP_AUTOINC_EN
//   When defined, each completed DATA read or write advances ADDRESS by 2.
//   The 16-bit add wraps 0xFFFE -> 0x0000.
//   When undefined, ADDRESS changes only through ADDRESS writes.
//
// Parameters
//   DEPTH_WORDS  internal memory size in 16-bit words (power of two, >= 16)
//
// Ports
//   clk            system clock; the HPI strobes come from the same domain
//   reset_n        asynchronous active-low reset
//   hpi_addr       register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_cs_n       chip select, active low
//   hpi_r_n        read strobe, active low
//   hpi_w_n        write strobe, active low
//   hpi_data_in    write data from host
//   hpi_data_out   read data to host, held for the whole drive phase
//   hpi_data_oe    high while a legal read is being driven
//   hpi_int        device-to-host mailbox full
//   mbx_in_data    last host-written mailbox word
//   mbx_in_valid   host-to-device mailbox full
//   mbx_in_ack     local consume of the host-to-device mailbox
//   mbx_out_data   word for the host
//   mbx_out_wr     single-cycle load of mbx_out_data into the outbound mailbox
//   mbx_out_busy   equals hpi_int
//   dbg_state_o    read FSM state: 0 IDLE, 1 FETCH, 2 DRIVE
//
// Mailbox handshake (both directions, valid/ready style):
//   The producer sets the flag (mbx_in_valid / hpi_int) when it loads a word.
//   The flag stays high until the consumer acknowledges: mbx_in_ack for the
//   inbound side, and a completed host MAILBOX read for the outbound side.
//   When a load and an acknowledge land in the same cycle, the load wins.
//   A reload while full overwrites the word.
// -----------------------------------------------------------------------------
module hpi_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic        hpi_int,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        mbx_out_busy,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef HPI_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_MAILBOX = 2'd1;
  localparam logic [1:0] REG_ADDRESS = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRIVE = 2'd2
  } rd_state_e;

  // ---------------------------------------------------------------------------
  // Strobe sampling and edge detection. The strobes, select and data are
  // registered together, so one access decodes from one coherent sample.
  // ---------------------------------------------------------------------------
  logic        cs_n_q, r_n_q, w_n_q;
  logic [1:0]  sel_s_q;
  logic [15:0] din_q;
  logic        rd_prev_q, wr_prev_q;
  logic        rd_act, wr_act, rd_edge, wr_edge;

  // All three low together decodes as neither access.
  assign rd_act  = !cs_n_q && !r_n_q &&  w_n_q;
  assign wr_act  = !cs_n_q && !w_n_q &&  r_n_q;
  assign rd_edge = rd_act && !rd_prev_q;
  assign wr_edge = wr_act && !wr_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_q    <= 1'b1;
      r_n_q     <= 1'b1;
      w_n_q     <= 1'b1;
      sel_s_q   <= 2'd0;
      din_q     <= 16'd0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      cs_n_q    <= hpi_cs_n;
      r_n_q     <= hpi_r_n;
      w_n_q     <= hpi_w_n;
      sel_s_q   <= hpi_addr;
      din_q     <= hpi_data_in;
      rd_prev_q <= rd_act;
      wr_prev_q <= wr_act;
    end
  end

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  rd_state_e   state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mbx_in_q, mbx_in_d;
  logic        mbx_in_vld_q, mbx_in_vld_d;
  logic [15:0] mbx_out_q, mbx_out_d;
  logic        int_q, int_d;
  logic [15:0] dout_q, dout_d;

  logic        mem_we, mem_re, rd_done;
  logic [15:0] mem_rd_q;
  logic [15:0] rd_mux;
  logic [AW-1:0] widx;

  // Byte address to word index; upper bits drop out so the address wraps.
  assign widx = addr_q[AW:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'd0;
      addr_q       <= 16'd0;
      mbx_in_q     <= 16'd0;
      mbx_in_vld_q <= 1'b0;
      mbx_out_q    <= 16'd0;
      int_q        <= 1'b0;
      dout_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      mbx_in_q     <= mbx_in_d;
      mbx_in_vld_q <= mbx_in_vld_d;
      mbx_out_q    <= mbx_out_d;
      int_q        <= int_d;
      dout_q       <= dout_d;
    end
  end

  // Word memory: contents survive reset, read is synchronous.
  logic [15:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= din_q;
    if (mem_re) mem_rd_q  <= mem[widx];
  end

  always_comb begin
    rd_mux = 16'd0;
    case (sel_q)
      REG_DATA:    rd_mux = mem_rd_q;
      REG_MAILBOX: rd_mux = mbx_out_q;
      REG_ADDRESS: rd_mux = addr_q;
      REG_STATUS:  rd_mux = {14'd0, int_q, mbx_in_vld_q};
      default:     rd_mux = 16'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM plus all register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    mbx_in_d     = mbx_in_q;
    mbx_in_vld_d = mbx_in_vld_q;
    mbx_out_d    = mbx_out_q;
    int_d        = int_q;
    dout_d       = dout_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    rd_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_edge) begin
          sel_d   = sel_s_q;
          mem_re  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cs_n_q) begin
          state_d = ST_IDLE;
        end else begin
          dout_d  = rd_mux;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Losing chip select aborts silently; a clean strobe release completes.
        if (cs_n_q) begin
          state_d = ST_IDLE;
        end else if (!rd_act) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Acknowledges come first so that a same-cycle load overrides them.
    if (mbx_in_ack) mbx_in_vld_d = 1'b0;

    if (rd_done) begin
      if (sel_q == REG_DATA && AUTOINC) addr_d = addr_q + 16'd2;
      if (sel_q == REG_MAILBOX)         int_d  = 1'b0;
    end

    if (mbx_out_wr) begin
      mbx_out_d = mbx_out_data;
      int_d     = 1'b1;
    end

    if (wr_edge) begin
      case (sel_s_q)
        REG_DATA: begin
          mem_we = 1'b1;
          if (AUTOINC) addr_d = addr_q + 16'd2;
        end
        REG_MAILBOX: begin
          mbx_in_d     = din_q;
          mbx_in_vld_d = 1'b1;
        end
        REG_ADDRESS: addr_d = din_q;
        default: ;  // STATUS is read-only
      endcase
    end
  end

  assign hpi_data_out = dout_q;
  assign hpi_data_oe  = (state_q == ST_DRIVE);
  assign hpi_int      = int_q;
  assign mbx_out_busy = int_q;
  assign mbx_in_data  = mbx_in_q;
  assign mbx_in_valid = mbx_in_vld_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_hpi_responder.sv
// -----------------------------------------------------------------------------
// tb_hpi_responder
//
// Directed bench for hpi_responder. It covers the burst and explicit DATA
// accesses, memory and address wrap, the mailbox round trip, load/consume
// collisions, illegal and held strobes, and reset during a read. Expected
// values are written out by hand. Where they depend on HPI_RESP_AUTOINC_EN,
// the bench selects the matching value.
// -----------------------------------------------------------------------------
module tb_hpi_responder;

`ifdef HPI_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_MBX  = 2'd1;
  localparam logic [1:0] R_ADDR = 2'd2;
  localparam logic [1:0] R_STAT = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  hpi_addr = 2'd0;
  logic        hpi_cs_n = 1'b1;
  logic        hpi_r_n = 1'b1;
  logic        hpi_w_n = 1'b1;
  logic [15:0] hpi_data_in = 16'd0;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic        hpi_int;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack = 1'b0;
  logic [15:0] mbx_out_data = 16'd0;
  logic        mbx_out_wr = 1'b0;
  logic        mbx_out_busy;
  logic [1:0]  dbg_state_o;

  hpi_responder #(.DEPTH_WORDS(1024)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hpi_addr     (hpi_addr),
    .hpi_cs_n     (hpi_cs_n),
    .hpi_r_n      (hpi_r_n),
    .hpi_w_n      (hpi_w_n),
    .hpi_data_in  (hpi_data_in),
    .hpi_data_out (hpi_data_out),
    .hpi_data_oe  (hpi_data_oe),
    .hpi_int      (hpi_int),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_busy (mbx_out_busy),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    hpi_addr = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    idle(4);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
    idle(2);
  endtask

  // Optional collision: loads cw through mbx_out_wr on the completion edge.
  task automatic host_read(input logic [1:0] a, input bit coll, input logic [15:0] cw,
                           output logic [15:0] d);
    int waited;
    @(negedge clk);
    hpi_addr = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    waited = 0;
    while (!hpi_data_oe && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rd_oe", {15'd0, hpi_data_oe}, 16'd1);
    d = hpi_data_out;
    idle(1);
    hpi_r_n = 1'b1;
    idle(1);
    if (coll) begin
      mbx_out_data = cw;
      mbx_out_wr   = 1'b1;
    end
    idle(1);
    mbx_out_wr = 1'b0;
    hpi_cs_n   = 1'b1;
    idle(2);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    host_write(R_ADDR, a);
    host_write(R_DATA, d);
  endtask

  task automatic read_word(input logic [15:0] a, output logic [15:0] d);
    host_write(R_ADDR, a);
    host_read(R_DATA, 1'b0, 16'd0, d);
  endtask

  task automatic local_load(input logic [15:0] d);
    @(negedge clk);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge clk);
    mbx_out_wr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [15:0] rd;

  initial begin
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Reset state
    check_eq("rst_dout",  hpi_data_out, 16'h0000);
    check_eq("rst_oe",    {15'd0, hpi_data_oe}, 16'd0);
    check_eq("rst_int",   {15'd0, hpi_int}, 16'd0);
    check_eq("rst_mvld",  {15'd0, mbx_in_valid}, 16'd0);
    check_eq("rst_mdata", mbx_in_data, 16'h0000);
    host_read(R_ADDR, 1'b0, 16'd0, rd); check_eq("rst_addr", rd, 16'h0000);
    host_read(R_STAT, 1'b0, 16'd0, rd); check_eq("rst_stat", rd, 16'h0000);

    // Burst write / read back
    host_write(R_ADDR, 16'h1000);
    host_write(R_DATA, 16'hAAAA);
    host_write(R_DATA, 16'h5555);
    host_write(R_DATA, 16'h1234);
    host_read(R_ADDR, 1'b0, 16'd0, rd);
    check_eq("burst_addr", rd, AUTOINC ? 16'h1006 : 16'h1000);
    host_write(R_ADDR, 16'h1000);
    exp_q.push_back(AUTOINC ? 16'hAAAA : 16'h1234);
    exp_q.push_back(AUTOINC ? 16'h5555 : 16'h1234);
    exp_q.push_back(16'h1234);
    for (int i = 0; i < 3; i++) begin
      host_read(R_DATA, 1'b0, 16'd0, rd);
      check_eq("burst_rd", rd, exp_q.pop_front());
    end
    host_read(R_ADDR, 1'b0, 16'd0, rd);
    check_eq("burst_addr2", rd, AUTOINC ? 16'h1006 : 16'h1000);

    // Explicit addressing
    write_word(16'h0010, 16'h1111);
    write_word(16'h0012, 16'h2222);
    read_word(16'h0010, rd); check_eq("word_10", rd, 16'h1111);
    read_word(16'h0012, rd); check_eq("word_12", rd, 16'h2222);
    host_read(R_ADDR, 1'b0, 16'd0, rd);
    check_eq("rd_inc_addr", rd, AUTOINC ? 16'h0014 : 16'h0012);

    // Memory-index wrap
    write_word(16'h0000, 16'h1357);
    host_write(R_ADDR, 16'h07FE);
    host_write(R_DATA, 16'hBEEF);
    host_write(R_DATA, 16'hBEEF);
    host_read(R_ADDR, 1'b0, 16'd0, rd);
    check_eq("wrap_addr", rd, AUTOINC ? 16'h0802 : 16'h07FE);
    read_word(16'h0000, rd); check_eq("wrap_idx0", rd, AUTOINC ? 16'hBEEF : 16'h1357);
    read_word(16'h07FE, rd); check_eq("wrap_top", rd, 16'hBEEF);
    read_word(16'h0801, rd); check_eq("wrap_alias", rd, AUTOINC ? 16'hBEEF : 16'h1357);
    // 16-bit address wrap
    host_write(R_ADDR, 16'hFFFE);
    host_write(R_DATA, 16'h5A5A);
    host_read(R_ADDR, 1'b0, 16'd0, rd);
    check_eq("addr16_wrap", rd, AUTOINC ? 16'h0000 : 16'hFFFE);

    // Mailbox round trip
    host_write(R_MBX, 16'h00C3);
    check_eq("mbx_in_vld", {15'd0, mbx_in_valid}, 16'd1);
    check_eq("mbx_in_dat", mbx_in_data, 16'h00C3);
    host_read(R_STAT, 1'b0, 16'd0, rd); check_eq("stat_in", rd, 16'h0001);
    @(negedge clk); mbx_in_ack = 1'b1;
    @(negedge clk); mbx_in_ack = 1'b0;
    check_eq("ack_clr", {15'd0, mbx_in_valid}, 16'd0);
    host_read(R_STAT, 1'b0, 16'd0, rd); check_eq("stat_ack", rd, 16'h0000);
    host_write(R_STAT, 16'hFFFF);
    host_read(R_STAT, 1'b0, 16'd0, rd); check_eq("stat_ro", rd, 16'h0000);
    local_load(16'h0F0F);
    check_eq("int_set",  {15'd0, hpi_int}, 16'd1);
    check_eq("busy_set", {15'd0, mbx_out_busy}, 16'd1);
    host_read(R_STAT, 1'b0, 16'd0, rd); check_eq("stat_out", rd, 16'h0002);
    host_read(R_MBX, 1'b0, 16'd0, rd); check_eq("mbx_rd", rd, 16'h0F0F);
    check_eq("int_clr", {15'd0, hpi_int}, 16'd0);

    // Same-cycle ack and host mailbox write: the write wins
    @(negedge clk);
    hpi_addr = R_MBX; hpi_data_in = 16'h0077; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    @(negedge clk);          // strobe sampled; write commits on the next edge
    mbx_in_ack = 1'b1;
    @(negedge clk);
    mbx_in_ack = 1'b0;
    idle(2);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
    idle(2);
    check_eq("ack_coll_vld", {15'd0, mbx_in_valid}, 16'd1);
    check_eq("ack_coll_dat", mbx_in_data, 16'h0077);
    @(negedge clk); mbx_in_ack = 1'b1;
    @(negedge clk); mbx_in_ack = 1'b0;

    // Collision: local load on the mailbox-read completion edge
    local_load(16'h1111);
    host_read(R_MBX, 1'b1, 16'h2222, rd);
    check_eq("coll_rd", rd, 16'h1111);
    check_eq("coll_int", {15'd0, hpi_int}, 16'd1);
    host_read(R_MBX, 1'b0, 16'd0, rd); check_eq("coll_rd2", rd, 16'h2222);
    check_eq("coll_int_clr", {15'd0, hpi_int}, 16'd0);

    // Illegal strobes: cs/r/w all low
    write_word(16'h0020, 16'h4444);
    host_write(R_ADDR, 16'h0020);
    @(negedge clk);
    hpi_addr = R_DATA; hpi_data_in = 16'h9999;
    hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("illegal_oe", {15'd0, hpi_data_oe}, 16'd0);
    end
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
    idle(2);
    host_read(R_ADDR, 1'b0, 16'd0, rd); check_eq("illegal_addr", rd, 16'h0020);
    read_word(16'h0020, rd); check_eq("illegal_mem", rd, 16'h4444);

    // Held write strobe: one write, at most one increment
    write_word(16'h0032, 16'h6666);
    host_write(R_ADDR, 16'h0030);
    @(negedge clk);
    hpi_addr = R_DATA; hpi_data_in = 16'h7777; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    idle(20);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
    idle(2);
    host_read(R_ADDR, 1'b0, 16'd0, rd);
    check_eq("held_addr", rd, AUTOINC ? 16'h0032 : 16'h0030);
    read_word(16'h0030, rd); check_eq("held_w0", rd, 16'h7777);
    read_word(16'h0032, rd); check_eq("held_w1", rd, 16'h6666);

    // Reset during FETCH
    host_write(R_MBX, 16'h00AA);
    local_load(16'h3333);
    host_write(R_ADDR, 16'h0010);
    @(negedge clk);
    hpi_addr = R_DATA; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    idle(2);
    check_eq("mid_rd_fetch", {14'd0, dbg_state_o}, 16'd1);
    reset_n = 1'b0;
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    check_eq("mrst_dout", hpi_data_out, 16'h0000);
    check_eq("mrst_oe",   {15'd0, hpi_data_oe}, 16'd0);
    check_eq("mrst_int",  {15'd0, hpi_int}, 16'd0);
    check_eq("mrst_mvld", {15'd0, mbx_in_valid}, 16'd0);
    check_eq("mrst_mdat", mbx_in_data, 16'h0000);
    check_eq("mrst_state", {14'd0, dbg_state_o}, 16'd0);
    host_read(R_ADDR, 1'b0, 16'd0, rd); check_eq("mrst_addr", rd, 16'h0000);
    host_read(R_MBX, 1'b0, 16'd0, rd);  check_eq("mrst_mbx", rd, 16'h0000);
    read_word(16'h0010, rd); check_eq("mrst_mem", rd, 16'h1111);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
